// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter turning NUM_REQ simple request ports into single-outstanding AXI4-Lite transactions.
// Optional response watchdog with drain of late responses: define AXIL_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module axil_req_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     req_grant,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [31:0]            req_rdata,
  output logic [1:0]             req_resp,
  output logic                   timeout_err,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [31:0]            awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [31:0]            wdata,
  input  logic                   bvalid,
  input  logic [1:0]             bresp,
  output logic                   bready,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [31:0]            araddr,
  input  logic                   rvalid,
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  output logic                   rready
);
  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("axil_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RRESP, S_DONE
`ifdef AXIL_ARB_TIMEOUT_EN
    , S_DRAIN
`endif
  } state_t;

  state_t               state_q;
  logic [IW-1:0]        ptr_q;
  logic [NUM_REQ-1:0]   grant_q, done_q;
  logic [31:0]          addr_q, wdata_q, rdata_q;
  logic [1:0]           resp_q;
  logic                 awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]        cnt_q;
  logic                 wr_q, drain_q, tmo_q;
  logic                 tmo_hit;
  assign tmo_hit     = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  // First asserted request at or after the pointer; scanning downward lets the smallest offset win.
  logic [IW-1:0] win_idx, cand, ptr_nxt;
  logic          win_found;
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
  assign ptr_nxt = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      drain_q   <= 1'b0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
`ifdef AXIL_ARB_TIMEOUT_EN
          cnt_q <= '0;
          wr_q  <= req_write[win_idx];
`endif
          if (win_found) begin
            ptr_q   <= ptr_nxt;
            grant_q <= NUM_REQ'(1) << win_idx;
            addr_q  <= req_addr[32*win_idx +: 32];
            wdata_q <= req_wdata[32*win_idx +: 32];
            if (req_write[win_idx]) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WADDR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_RADDR;
            end
          end
        end
        S_WADDR: begin
          // AW and W retire independently; move on once neither is still pending.
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
            bready_q <= 1'b1;
            state_q  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            resp_q   <= bresp;
            rdata_q  <= '0;
            done_q   <= grant_q;
            state_q  <= S_DONE;
          end
`ifdef AXIL_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            bready_q <= 1'b0;
            resp_q   <= 2'b11;
            rdata_q  <= '0;
            done_q   <= grant_q;
            tmo_q    <= 1'b1;
            drain_q  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_RADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RRESP;
          end
        end
        S_RRESP: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            rdata_q  <= rdata;
            resp_q   <= rresp;
            done_q   <= grant_q;
            state_q  <= S_DONE;
          end
`ifdef AXIL_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            rready_q <= 1'b0;
            resp_q   <= 2'b11;
            rdata_q  <= '0;
            done_q   <= grant_q;
            tmo_q    <= 1'b1;
            drain_q  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_DONE: begin
          grant_q <= '0;
          rdata_q <= '0;
          resp_q  <= '0;
          state_q <= S_IDLE;
`ifdef AXIL_ARB_TIMEOUT_EN
          // A timed-out transaction still owes the slave one response; swallow it before re-arbitrating.
          if (drain_q) begin
            bready_q <= wr_q;
            rready_q <= !wr_q;
            state_q  <= S_DRAIN;
          end
`endif
        end
`ifdef AXIL_ARB_TIMEOUT_EN
        S_DRAIN: begin
          if (wr_q ? bvalid : rvalid) begin
            bready_q <= 1'b0;
            rready_q <= 1'b0;
            drain_q  <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_grant = grant_q;
  assign req_done  = done_q;
  assign req_rdata = rdata_q;
  assign req_resp  = resp_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = addr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = addr_q;
  assign rready    = rready_q;
endmodule

// File: tb/tb_axil_req_arbiter.sv
// Bench for axil_req_arbiter: behavioural AXI4-Lite slave, round-robin/memory reference model, directed + random steps.
`timescale 1ns/1ps
module tb_axil_req_arbiter;
  localparam int N   = 2;
  localparam int TMO = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [N-1:0]    req_valid, req_write, req_grant, req_done;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [31:0]     req_rdata;
  logic [1:0]      req_resp;
  logic            timeout_err;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [31:0]     awaddr, wdata, araddr, rdata;
  logic [1:0]      bresp, rresp;

  axil_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .req_done(req_done), .req_rdata(req_rdata), .req_resp(req_resp),
    .timeout_err(timeout_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural AXI4-Lite slave: 4 KiB RAM, SLVERR above it ----------------
  int  aw_pct = 100, w_pct = 100, ar_pct = 100, gap_max = 0, w_lag = -1;
  bit  b_hold = 0, r_hold = 0;
  logic [31:0] smem [0:1023];
  int  n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, cyc = 0, aw_cyc = 0, w_cyc = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  bit  have_aw, have_w, have_ar;
  logic [31:0] pa, pd, pra;
  int  gap, lagc;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= '0;
      arready <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= '0;
      have_aw = 0; have_w = 0; have_ar = 0; gap = 0; lagc = 0;
    end else begin
      cyc++;
      if (awvalid && awready) begin have_aw = 1; pa = awaddr; n_aw++; last_awaddr = awaddr; aw_cyc = cyc; lagc = 0; end
      if (wvalid && wready)   begin have_w = 1; pd = wdata; n_w++; last_wdata = wdata; w_cyc = cyc; end
      if (arvalid && arready) begin have_ar = 1; pra = araddr; n_ar++; last_araddr = araddr; end
      if (bvalid && bready) begin bvalid <= 1'b0; n_b++; end
      if (rvalid && rready) begin rvalid <= 1'b0; n_r++; end
      if (have_aw && !have_w) lagc++;
      awready <= !have_aw && ($urandom_range(0, 99) < aw_pct);
      if (w_lag >= 0) wready <= have_aw && !have_w && (lagc >= w_lag);
      else            wready <= !have_w && ($urandom_range(0, 99) < w_pct);
      arready <= !have_ar && ($urandom_range(0, 99) < ar_pct);
      if (have_aw && have_w && !b_hold) begin
        if (gap == 0) begin
          if (pa < 32'h1000) begin smem[pa[11:2]] = pd; bresp <= 2'b00; end
          else bresp <= 2'b10;
          bvalid <= 1'b1; have_aw = 0; have_w = 0; gap = $urandom_range(0, gap_max);
        end else gap--;
      end
      if (have_ar && !r_hold) begin
        if (gap == 0) begin
          if (pra < 32'h1000) begin rdata <= smem[pra[11:2]]; rresp <= 2'b00; end
          else begin rdata <= '0; rresp <= 2'b10; end
          rvalid <= 1'b1; have_ar = 0; gap = $urandom_range(0, gap_max);
        end else gap--;
      end
    end
  end

  // AXI valids and their payload must hold until the handshake.
  logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rst;
  logic [31:0] p_awa, p_ara;
  always @(negedge aclk) begin
    if (aresetn && p_rst) begin
      if (p_awv && !p_awr) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awa});
      if (p_wv && !p_wr)   chk("w_hold", wvalid, 1);
      if (p_arv && !p_arr) chk("ar_hold", {arvalid, araddr}, {1'b1, p_ara});
    end
    p_rst = aresetn; p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
    p_arv = arvalid; p_arr = arready; p_awa = awaddr; p_ara = araddr;
  end

  // ---------------- reference model ----------------
  typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] data; } op_t;
  op_t opq [N][$];
  op_t cur_op [N];
  logic [31:0] mmem [logic [31:0]];
  int  ptr_m = 0, cur = -1, raise_pct = 100;
  bit  zero_wait = 0;
  int  gseq [$];

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [33:0] expect_op(input op_t o);
    if (o.addr >= 32'h1000) return {2'b10, 32'h0};
    if (o.wr) return {2'b00, 32'h0};
    return {2'b00, mmem.exists(o.addr) ? mmem[o.addr] : 32'h0};
  endfunction

  task automatic run(input int budget);
    logic [N-1:0] gprev, dprev;
    logic [33:0]  e;
    int t, gt, w, g, pending;
    gprev = '0; dprev = '0; t = 0; gt = 0;
    while (t < budget) begin
      @(posedge aclk); #1; t++;
      if (req_grant !== '0 && gprev === '0) begin
        w = rr_pick(req_valid, ptr_m);
        g = -1;
        for (int i = 0; i < N; i++) if (req_grant[i]) g = i;
        gseq.push_back(g);
        if (w >= 0) begin
          chk("grant", req_grant, N'(1) << w);
          chk("axi_addr", cur_op[w].wr ? awaddr : araddr, cur_op[w].addr);
          ptr_m = (w + 1) % N;
        end else chk("grant_without_req", req_grant, 0);
        cur = w; gt = t;
      end
      if (req_done !== '0) begin
        chk("done_pulse", dprev, 0);
        if (cur >= 0) begin
          e = expect_op(cur_op[cur]);
          chk("done_who", req_done, N'(1) << cur);
          chk("resp", req_resp, e[33:32]);
          chk("rdata", req_rdata, e[31:0]);
          if (cur_op[cur].wr) chk("axi_wdata", last_wdata, cur_op[cur].data);
          // grant observed in cycle 1 (address phase); DONE must be cycle 3 with a zero-wait slave
          if (zero_wait) chk("latency", t - gt + 1, 3);
          if (cur_op[cur].wr && cur_op[cur].addr < 32'h1000) mmem[cur_op[cur].addr] = cur_op[cur].data;
          cur = -1;
        end
      end
      gprev = req_grant; dprev = req_done;
      @(negedge aclk);
      for (int i = 0; i < N; i++) begin
        if (dprev[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && opq[i].size() > 0 && $urandom_range(0, 99) < raise_pct) begin
          cur_op[i] = opq[i].pop_front();
          req_valid[i] = 1'b1;
          req_write[i] = cur_op[i].wr;
          req_addr[32*i +: 32]  = cur_op[i].addr;
          req_wdata[32*i +: 32] = cur_op[i].data;
        end
      end
      pending = $countones(req_valid);
      for (int i = 0; i < N; i++) pending += opq[i].size();
      if (pending == 0 && req_grant === '0) break;
    end
    pending = $countones(req_valid);
    for (int i = 0; i < N; i++) pending += opq[i].size();
    chk("run_unfinished_ops", pending, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_grant"}, req_grant, 0);
    chk({tag, "_done"}, req_done, 0);
    chk({tag, "_rdata_resp"}, {req_rdata, req_resp}, 0);
    chk({tag, "_axi_valids"}, {awvalid, wvalid, arvalid}, 0);
    chk({tag, "_axi_readys"}, {bready, rready}, 0);
  endtask

  initial begin
    int n0, n1, n2, n3, k, exp_seq [4];
    op_t o;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 1024; i++) smem[i] = '0;
    exp_seq = '{0, 1, 0, 1};

    // reset values
    repeat (3) @(negedge aclk);
    chk_outputs_zero("reset");
    chk("reset_addr", {awaddr, araddr, wdata}, 0);
    chk("reset_tmo", timeout_err, 0);
    aresetn = 1'b1;

    // req0 writes DEADBEEF to 0x04, zero-wait slave
    zero_wait = 1;
    n0 = n_aw; n1 = n_w; n2 = n_b;
    opq[0].push_back('{1'b1, 32'h4, 32'hDEADBEEF});
    run(100);
    chk("wr_aw_count", n_aw - n0, 1);
    chk("wr_w_count", n_w - n1, 1);
    chk("wr_b_count", n_b - n2, 1);
    chk("wr_awaddr", last_awaddr, 32'h4);

    // req1 reads 0x04 back
    n0 = n_ar;
    opq[1].push_back('{1'b0, 32'h4, 32'h0});
    run(100);
    chk("rd_ar_count", n_ar - n0, 1);
    chk("rd_araddr", last_araddr, 32'h4);

    // both requesters hold reads: strict alternation
    gseq.delete();
    for (int r = 0; r < 2; r++) begin
      opq[0].push_back('{1'b0, 32'h4, 32'h0});
      opq[1].push_back('{1'b0, 32'h8, 32'h0});
    end
    run(200);
    chk("rr_seq_len", gseq.size(), 4);
    for (int i = 0; i < 4 && i < gseq.size(); i++) chk("rr_seq", gseq[i], exp_seq[i]);

    // out-of-range write then read: SLVERR
    opq[0].push_back('{1'b1, 32'h2000, 32'hAAAA5555});
    opq[0].push_back('{1'b0, 32'h2000, 32'h0});
    run(200);

    // W lags AW by three cycles
    zero_wait = 0; w_lag = 3;
    n0 = n_aw; n1 = n_w; n2 = n_b; n3 = 0;
    opq[1].push_back('{1'b1, 32'h10, 32'h12345678});
    run(200);
    chk("lag_aw_count", n_aw - n0, 1);
    chk("lag_w_count", n_w - n1, 1);
    chk("lag_b_count", n_b - n2, 1);
    chk("lag_w_after_aw", w_cyc - aw_cyc, 3);
    w_lag = -1;

    // random traffic with a stalling slave
    aw_pct = 60; w_pct = 60; ar_pct = 60; gap_max = 3; raise_pct = 50;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 20; j++) begin
        o.wr   = 1'($urandom_range(0, 1));
        o.addr = ($urandom_range(0, 7) == 0) ? 32'h2000 + 4 * $urandom_range(0, 3) : 4 * $urandom_range(0, 15);
        o.data = $urandom;
        opq[i].push_back(o);
      end
    run(20000);
    chk("rand_tmo", timeout_err, 0);
    aw_pct = 100; w_pct = 100; ar_pct = 100; gap_max = 0; raise_pct = 100;

    // reset while waiting in RRESP
    r_hold = 1;
    @(negedge aclk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[31:0] = 32'h4;
    k = 0;
    while (k < 50) begin
      @(posedge aclk); #1; k++;
      if (rready === 1'b1) break;
    end
    chk("rresp_reached", rready, 1);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    req_valid = '0;
    repeat (2) @(negedge aclk);
    r_hold = 0; ptr_m = 0; cur = -1;
    aresetn = 1'b1;
    zero_wait = 1;
    opq[0].push_back('{1'b0, 32'h4, 32'h0});
    run(100);

`ifdef AXIL_ARB_TIMEOUT_EN
    // slave withholds B: watchdog fires after TMO cycles in WRESP, late B is drained
    zero_wait = 0; b_hold = 1;
    @(negedge aclk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[31:0] = 32'h8; req_wdata[31:0] = 32'hCAFEF00D;
    k = 0; n3 = 0;
    while (k < 100) begin
      @(posedge aclk); #1; k++;
      if (bready === 1'b1) n3++;
      if (req_done[0] === 1'b1) break;
    end
    chk("tmo_done", req_done, 1);
    chk("tmo_wresp_cycles", n3, TMO);
    chk("tmo_resp", {req_resp, req_rdata}, {2'b11, 32'h0});
    chk("tmo_flag", timeout_err, 1);
    @(negedge aclk);
    req_valid = '0;
    n2 = n_b; b_hold = 0;
    k = 0;
    while (k < 50 && n_b == n2) begin @(posedge aclk); #1; k++; end
    chk("drain_b_count", n_b - n2, 1);
    @(posedge aclk); #1;
    chk("drain_idle", {req_grant, bready, rready}, 0);
    chk("tmo_sticky", timeout_err, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
